serializer_gearbox: RTL and testbench

SERIALIZER_GEARBOX -- requirements
Module: serializer_gearbox

---
 rtl/serializer_gearbox.sv | 115 +++++++++++
 tb/tb_serializer_gearbox.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serializer_gearbox.sv
// Multi-lane parallel-to-serial gearbox sharing one bit counter.
// One-entry holding buffer decouples the source handshake from word boundaries.
module serializer_gearbox #(
   parameter int DATA_WIDTH = 10,
   parameter int LANES = 3,
   parameter bit LSB_FIRST = 1'b1,
   parameter logic [DATA_WIDTH-1:0] IDLE_WORD = 10'b1101010100
) (
   input  logic                        serial_clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [LANES*DATA_WIDTH-1:0] paralell_data,
   input  logic                        paralell_valid,
   output logic                        paralell_ready,
   output logic [LANES-1:0]            serial_data_out,
   output logic                        word_start,
   output logic                        underrun,
   input  logic                        underrun_clr
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t                                 state;
   state_t                                 state_nxt;
   logic [CW-1:0]                          bit_cnt;
   logic                                   boundary;
   logic                                   xfer;
   logic                                   ur_set;
   logic                                   hold_full;
   logic [LANES*DATA_WIDTH-1:0]            hold_data;
   logic [LANES-1:0][DATA_WIDTH-1:0]       shreg;

   assign boundary       = (bit_cnt == LAST);
   assign paralell_ready = enable & (~hold_full | boundary);
   assign xfer           = paralell_valid & paralell_ready;
   assign word_start     = (bit_cnt == '0);

   // Free-running: frame alignment never depends on traffic.
   always_ff @(posedge serial_clk or posedge reset) begin
      if (reset)
         bit_cnt <= '0;
      else if (boundary)
         bit_cnt <= '0;
      else
         bit_cnt <= bit_cnt + 1'b1;
   end

   always_ff @(posedge serial_clk or posedge reset) begin
      if (reset) begin
         hold_full <= 1'b0;
         hold_data <= '0;
      end else if (xfer) begin
         hold_full <= 1'b1;
         hold_data <= paralell_data;
      end else if (boundary) begin
         hold_full <= 1'b0;
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      always_ff @(posedge serial_clk or posedge reset) begin
         if (reset)
            shreg[k] <= IDLE_WORD;
         else if (boundary)
            shreg[k] <= hold_full ?
                        hold_data[k*DATA_WIDTH +: DATA_WIDTH] : IDLE_WORD;
         else if (LSB_FIRST)
            shreg[k] <= shreg[k] >> 1;
         else
            shreg[k] <= shreg[k] << 1;
      end

      assign serial_data_out[k] = LSB_FIRST ? shreg[k][0] :
                                  shreg[k][DATA_WIDTH-1];
   end

   always_ff @(posedge serial_clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (boundary && hold_full) state_nxt = RUN;
         RUN:  if (boundary && !hold_full && !enable) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A missing word only counts as underrun while a stream is running.
   always_comb begin
      ur_set = 1'b0;
      if (state == RUN)
         ur_set = boundary & ~hold_full & enable;
   end

   always_ff @(posedge serial_clk or posedge reset) begin
      if (reset)
         underrun <= 1'b0;
      else if (ur_set)
         underrun <= 1'b1;
      else if (underrun_clr)
         underrun <= 1'b0;
   end

endmodule

// File: tb/tb_serializer_gearbox.sv
// Scoreboard bench: word-level model predicts per-cycle serial frames,
// a negedge monitor pops and compares them against both bit orders.
module tb_serializer_gearbox;

   localparam int DW = 10;
   localparam int LN = 3;
   localparam logic [DW-1:0] IDLE = 10'b1101010100;
   localparam logic [LN*DW-1:0] IDLE_ALL = {LN{IDLE}};

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic enable = 1'b0;
   logic valid = 1'b0;
   logic clr = 1'b0;
   logic [LN*DW-1:0] data = '0;

   logic ready, ready_m;
   logic [LN-1:0] sout, sout_m;
   logic ws, ws_m, ur, ur_m;

   serializer_gearbox #(.DATA_WIDTH(DW), .LANES(LN), .LSB_FIRST(1'b1),
                        .IDLE_WORD(IDLE)) u_lsb (
      .serial_clk(clk), .reset(reset), .enable(enable),
      .paralell_data(data), .paralell_valid(valid),
      .paralell_ready(ready), .serial_data_out(sout),
      .word_start(ws), .underrun(ur), .underrun_clr(clr));

   serializer_gearbox #(.DATA_WIDTH(DW), .LANES(LN), .LSB_FIRST(1'b0),
                        .IDLE_WORD(IDLE)) u_msb (
      .serial_clk(clk), .reset(reset), .enable(enable),
      .paralell_data(data), .paralell_valid(valid),
      .paralell_ready(ready_m), .serial_data_out(sout_m),
      .word_start(ws_m), .underrun(ur_m), .underrun_clr(clr));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [LN-1:0] lb;
      logic [LN-1:0] mb;
   } rec_t;

   rec_t expq[$];
   logic [LN*DW-1:0] wq[$];
   int phase = 0;
   bit running = 1'b0;
   bit m_ur = 1'b0;
   bit m_xfer = 1'b0;
   int total = 0;
   int bad = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void push_frame(logic [LN*DW-1:0] w);
      for (int i = 0; i < DW; i++) begin
         rec_t r;
         for (int k = 0; k < LN; k++) begin
            r.lb[k] = w[k*DW + i];
            r.mb[k] = w[k*DW + DW - 1 - i];
         end
         expq.push_back(r);
      end
   endfunction

   // Word-level model: each frame slot carries the oldest word accepted
   // before that slot began, otherwise the idle word.
   always @(posedge clk or posedge reset) begin : model
      bit bnd;
      bit set;
      if (reset) begin
         expq.delete();
         wq.delete();
         phase = 0;
         running = 1'b0;
         m_ur = 1'b0;
         m_xfer = 1'b0;
         push_frame(IDLE_ALL);
      end else begin
         bnd = (phase == DW - 1);
         set = 1'b0;
         m_xfer = valid && enable && (wq.size() == 0 || bnd);
         if (bnd) begin
            if (wq.size() > 0) begin
               push_frame(wq.pop_front());
               running = 1'b1;
            end else begin
               push_frame(IDLE_ALL);
               if (running) begin
                  if (enable) set = 1'b1;
                  else running = 1'b0;
               end
            end
         end
         if (m_xfer) wq.push_back(data);
         if (set) m_ur = 1'b1;
         else if (clr) m_ur = 1'b0;
         phase = (phase + 1) % DW;
      end
   end

   always @(negedge clk) begin : monitor
      rec_t r;
      bit exp_rdy;
      if (!reset) begin
         if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL exp_queue: got empty want frame at %0t", $time);
         end else begin
            r = expq.pop_front();
            exp_rdy = enable && (wq.size() == 0 || phase == DW - 1);
            chk("lsb_bits", 32'(sout), 32'(r.lb));
            chk("msb_bits", 32'(sout_m), 32'(r.mb));
            chk("word_start", 32'(ws), 32'(phase == 0));
            chk("word_start_m", 32'(ws_m), 32'(phase == 0));
            chk("ready", 32'(ready), 32'(exp_rdy));
            chk("ready_m", 32'(ready_m), 32'(exp_rdy));
            chk("underrun", 32'(ur), 32'(m_ur));
            chk("underrun_m", 32'(ur_m), 32'(m_ur));
         end
      end
   end

   task automatic cyc(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(logic [LN*DW-1:0] w);
      bit ok;
      ok = 1'b0;
      valid = 1'b1;
      data = w;
      for (int i = 0; i < 40; i++) begin
         cyc(1);
         if (m_xfer) begin
            ok = 1'b1;
            break;
         end
      end
      valid = 1'b0;
      chk("send_accept", 32'(ok), 32'd1);
   endtask

   task automatic wait_phase(int p);
      for (int i = 0; i <= DW; i++) begin
         if (phase == p) break;
         cyc(1);
      end
      chk("phase_reached", 32'(phase), 32'(p));
   endtask

   initial begin
      int n;
      enable = 1'b1;
      #2 reset = 1'b1;
      #1;
      chk("rst_sout", 32'(sout), 32'({LN{IDLE[0]}}));
      chk("rst_sout_m", 32'(sout_m), 32'({LN{IDLE[DW-1]}}));
      chk("rst_ws", 32'(ws), 32'd1);
      chk("rst_ur", 32'(ur), 32'd0);
      chk("rst_ready", 32'(ready), 32'(enable));
      cyc(3);
      reset = 1'b0;

      cyc(30);

      send({10'h155, 10'h000, 10'h3FF});
      cyc(25);
      chk("single_underrun", 32'(ur), 32'd1);

      wait_phase(DW - 1);
      clr = 1'b1;
      cyc(1);
      chk("set_wins", 32'(ur), 32'd1);
      cyc(1);
      clr = 1'b0;
      chk("clr_works", 32'(ur), 32'd0);

      n = 0;
      valid = 1'b1;
      data = (LN*DW)'($urandom);
      for (int i = 0; i < 700 && n < 50; i++) begin
         cyc(1);
         if (m_xfer) begin
            n++;
            data = (LN*DW)'($urandom);
         end
      end
      valid = 1'b0;
      chk("stream_count", 32'(n), 32'd50);
      chk("stream_underrun", 32'(ur), 32'd0);

      cyc(30);
      enable = 1'b0;
      cyc(25);
      clr = 1'b1;
      cyc(1);
      clr = 1'b0;
      enable = 1'b1;
      send((LN*DW)'($urandom));
      enable = 1'b0;
      cyc(30);
      chk("drain_underrun", 32'(ur), 32'd0);
      enable = 1'b1;
      cyc(25);
      chk("back_to_idle", 32'(ur), 32'd0);

      wait_phase(1);
      send({10'h2AA, 10'h0F0, 10'h33C});
      wait_phase(5);
      reset = 1'b1;
      #1;
      chk("midrst_sout", 32'(sout), 32'({LN{IDLE[0]}}));
      chk("midrst_ws", 32'(ws), 32'd1);
      cyc(2);
      reset = 1'b0;
      cyc(30);

      repeat (400) begin
         enable = ($urandom_range(0, 9) != 0);
         valid = ($urandom_range(0, 2) != 0);
         clr = ($urandom_range(0, 15) == 0);
         data = (LN*DW)'($urandom);
         cyc(1);
      end
      valid = 1'b0;
      clr = 1'b0;
      cyc(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
